// File: rtl/prio_req_arbiter.sv
// prio_req_arbiter: shares one downstream resource among 8 requesters.
// A winner is chosen by fixed priority (bit 7 highest) or round-robin from
// a rotating pointer. The one-hot grant is held while the owner keeps
// requesting, up to HOLD_MAX cycles. One idle gap cycle follows every
// release before arbitration resumes. The granted index is also shown on
// an active-low 7-segment digit.

module prio_req_arbiter #(
    parameter int HOLD_MAX = 15,
    parameter int CNTW     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       mode,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic [6:0] seg0
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Hold-counter value reached during the owner's final permitted cycle.
    localparam logic [CNTW-1:0] LP_CNT_LAST = CNTW'(HOLD_MAX - 1);
    localparam logic [6:0]      LP_SEG_BLANK = 7'b1111111;

    // 8-to-3 encoder returning the index of the highest set bit (0 if none).
    function automatic logic [2:0] enc_hi8(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // 8-to-3 encoder returning the index of the lowest set bit (0 if none).
    function automatic logic [2:0] enc_lo8(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Rotate v down by sh so that bit sh lands at position 0.
    function automatic logic [7:0] rot_down(input logic [7:0] v, input logic [2:0] sh);
        logic [7:0] r;
        logic [2:0] j;
        r = 8'd0;
        for (int i = 0; i < 8; i++) begin
            j    = 3'(i) + sh;
            r[i] = v[j];
        end
        return r;
    endfunction

    // Expand an index into a one-hot 8-bit vector.
    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

    // Active-low {g,f,e,d,c,b,a} pattern for one octal digit.
    function automatic logic [6:0] seg_digit(input logic [2:0] d);
        logic [6:0] s;
        case (d)
            3'd0:    s = 7'b1000000;
            3'd1:    s = 7'b1111001;
            3'd2:    s = 7'b0100100;
            3'd3:    s = 7'b0110000;
            3'd4:    s = 7'b0011001;
            3'd5:    s = 7'b0010010;
            3'd6:    s = 7'b0000010;
            3'd7:    s = 7'b1111000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    state_t          r_state;
    logic [7:0]      r_gnt;
    logic [2:0]      r_gnt_idx;
    logic            r_gnt_vld;
    logic [6:0]      r_seg0;
    logic [CNTW-1:0] r_cnt;
    logic [2:0]      r_ptr;

    logic [7:0]      w_rot;
    logic [2:0]      w_hi;
    logic [2:0]      w_lo;
    logic [2:0]      w_win;
    logic            w_any;
    logic            w_release;

    // Winner selection: highest bit, or first bit at/after the pointer.
    always_comb begin
        w_rot = rot_down(req, r_ptr);
        w_hi  = enc_hi8(req);
        w_lo  = enc_lo8(w_rot);
        w_any = |req;
        if (mode) begin
            w_win = r_ptr + w_lo;
        end else begin
            w_win = w_hi;
        end
    end

    // Release decision for the current owner; any single cause suffices.
    always_comb begin
        w_release = 1'b0;
        if (!en) begin
            w_release = 1'b1;
        end else if (!req[r_gnt_idx]) begin
            w_release = 1'b1;
        end else if (r_cnt == LP_CNT_LAST) begin
            w_release = 1'b1;
        end else begin
            w_release = 1'b0;
        end
    end

    // Arbitration state machine with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= 8'd0;
            r_gnt_idx <= 3'd0;
            r_gnt_vld <= 1'b0;
            r_seg0    <= LP_SEG_BLANK;
            r_cnt     <= '0;
            r_ptr     <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en && w_any) begin
                        r_state   <= ST_GRANT;
                        r_gnt     <= onehot8(w_win);
                        r_gnt_idx <= w_win;
                        r_gnt_vld <= 1'b1;
                        r_seg0    <= seg_digit(w_win);
                        r_cnt     <= '0;
                    end else begin
                        r_state   <= ST_IDLE;
                        r_gnt     <= 8'd0;
                        r_gnt_idx <= 3'd0;
                        r_gnt_vld <= 1'b0;
                        r_seg0    <= LP_SEG_BLANK;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_state   <= ST_GAP;
                        r_gnt     <= 8'd0;
                        r_gnt_idx <= 3'd0;
                        r_gnt_vld <= 1'b0;
                        r_seg0    <= LP_SEG_BLANK;
                        r_ptr     <= r_gnt_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + {{(CNTW-1){1'b0}}, 1'b1};
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_gnt     <= 8'd0;
                    r_gnt_idx <= 3'd0;
                    r_gnt_vld <= 1'b0;
                    r_seg0    <= LP_SEG_BLANK;
                    r_cnt     <= '0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign gnt_vld = r_gnt_vld;
    assign seg0    = r_seg0;

    prio_req_arbiter_chk u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .gnt     (r_gnt),
        .gnt_idx (r_gnt_idx),
        .gnt_vld (r_gnt_vld)
    );

endmodule

// Grant-consistency properties for prio_req_arbiter.
module prio_req_arbiter_chk (
    input logic       clk,
    input logic       rst_n,
    input logic [7:0] gnt,
    input logic [2:0] gnt_idx,
    input logic       gnt_vld
);

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt));

    a_vld: assert property (@(posedge clk) disable iff (!rst_n)
        gnt_vld == (|gnt));

    a_idx: assert property (@(posedge clk) disable iff (!rst_n)
        gnt == (gnt_vld ? (8'd1 << gnt_idx) : 8'd0));

endmodule
